// File: rtl/hba_quad_pkg.sv
// Shared definitions for the HBA quadrature sample scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hba_quad_pkg;

    localparam int LEFT          = 0;
    localparam int RIGHT         = 1;
    localparam int CNT_WIDTH_DEF = 16;
    localparam int PER_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_REQ_L = 3'd2,
        ST_ACK_L = 3'd3,
        ST_REQ_R = 3'd4,
        ST_ACK_R = 3'd5,
        ST_CALC  = 3'd6,
        ST_PUB   = 3'd7
    } state_t;

endpackage

// File: rtl/quad_tick_gen.sv
// Tick prescaler plus period counter; pulses expire once per sample period.
// Latency: expire is combinational from the counter state (same cycle as the final tick).
// Backpressure: none; both counters are held at zero while run is low.
module quad_tick_gen #(
    parameter int PER_WIDTH = 8,
    parameter int CLK_DIV   = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [PER_WIDTH-1:0] period,
    output logic                 expire
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]        presc;
    logic [PER_WIDTH-1:0] pcnt;
    logic                 tick;

    assign tick   = run && (presc == DW'(CLK_DIV - 1));
    // Compared against the live period so a change applies at the next compare;
    // a count already past period-1 simply runs on through the natural wrap.
    assign expire = tick && (pcnt == (period - PER_WIDTH'(1)));

    // Prescaler wraps at CLK_DIV-1; period counter advances on each tick and reloads on expiry.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            presc <= '0;
            pcnt  <= '0;
        end else begin
            presc <= tick ? '0 : presc + DW'(1);
            if (tick) begin
                pcnt <= expire ? '0 : pcnt + PER_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/hba_quad_sampler.sv
// Periodic left/right counter snapshot scheduler with signed per-period deltas and sticky irq.
// Latency: period expiry to sample_valid is 6 cycles when each ack arrives the cycle after its req.
// Backpressure: waits on snap_ack per counter; QUAD_SAMPLE_TIMEOUT_EN adds an ack timeout and err flag.
module hba_quad_sampler
    import hba_quad_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int PER_WIDTH = PER_WIDTH_DEF,
    parameter int CLK_DIV   = 50000
`ifdef QUAD_SAMPLE_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 255
`endif
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset,
    input  logic                   en,
    input  logic [PER_WIDTH-1:0]   period,
    output logic [1:0]             snap_req,
    input  logic [1:0]             snap_ack,
    input  logic [2*CNT_WIDTH-1:0] cnt_in,
    output logic [CNT_WIDTH-1:0]   count_l,
    output logic [CNT_WIDTH-1:0]   count_r,
    output logic [CNT_WIDTH-1:0]   delta_l,
    output logic [CNT_WIDTH-1:0]   delta_r,
    output logic                   sample_valid,
    output logic [7:0]             seq,
    output logic                   irq,
    input  logic                   irq_clr,
    output logic                   overrun,
    output logic                   miss
`ifdef QUAD_SAMPLE_TIMEOUT_EN
    ,
    output logic                   err
`endif
);

    state_t               state, nstate;
    logic                 run;
    logic                 expire;
    logic                 prev_valid;
    logic [CNT_WIDTH-1:0] cap_l, cap_r, prev_l, prev_r;

`ifdef QUAD_SAMPLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo;
    logic          tmo_hit;
`endif

    // Dropping en or zeroing period stops everything on the next edge.
    assign run = en && (period != '0);

    quad_tick_gen #(
        .PER_WIDTH (PER_WIDTH),
        .CLK_DIV   (CLK_DIV)
    ) u_tick (
        .clk    (hba_clk),
        .reset  (hba_reset),
        .run    (run),
        .period (period),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) state <= ST_IDLE;
        else           state <= nstate;
    end

    // Next state and handshake strobes; an ack is only looked at in ACK_x, so one in the req cycle is ignored.
    always_comb begin
        nstate       = state;
        snap_req     = 2'b00;
        sample_valid = 1'b0;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
        tmo_hit      = 1'b0;
`endif
        case (state)
            ST_IDLE:  nstate = ST_WAIT;
            ST_WAIT:  if (expire) nstate = ST_REQ_L;
            ST_REQ_L: begin
                snap_req[LEFT] = 1'b1;
                nstate         = ST_ACK_L;
            end
            ST_ACK_L: begin
                if (snap_ack[LEFT]) nstate = ST_REQ_R;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
                else if (tmo == TW'(TIMEOUT - 1)) begin
                    nstate  = ST_WAIT;
                    tmo_hit = 1'b1;
                end
`endif
            end
            ST_REQ_R: begin
                snap_req[RIGHT] = 1'b1;
                nstate          = ST_ACK_R;
            end
            ST_ACK_R: begin
                if (snap_ack[RIGHT]) nstate = ST_CALC;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
                else if (tmo == TW'(TIMEOUT - 1)) begin
                    nstate  = ST_WAIT;
                    tmo_hit = 1'b1;
                end
`endif
            end
            ST_CALC:  nstate = ST_PUB;
            ST_PUB: begin
                sample_valid = 1'b1;
                nstate       = ST_WAIT;
            end
            default:  nstate = ST_IDLE;
        endcase
        if (!run) begin
            nstate       = ST_IDLE;
            snap_req     = 2'b00;
            sample_valid = 1'b0;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
            tmo_hit      = 1'b0;
`endif
        end
    end

    // Capture, delta computation, published outputs and sticky flags.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            cap_l      <= '0;
            cap_r      <= '0;
            prev_l     <= '0;
            prev_r     <= '0;
            prev_valid <= 1'b0;
            count_l    <= '0;
            count_r    <= '0;
            delta_l    <= '0;
            delta_r    <= '0;
            seq        <= '0;
            irq        <= 1'b0;
            overrun    <= 1'b0;
            miss       <= 1'b0;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
            err        <= 1'b0;
            tmo        <= '0;
`endif
        end else begin
            if (!run) prev_valid <= 1'b0;
            if (run && state == ST_ACK_L && snap_ack[LEFT])
                cap_l <= cnt_in[LEFT*CNT_WIDTH +: CNT_WIDTH];
            if (run && state == ST_ACK_R && snap_ack[RIGHT])
                cap_r <= cnt_in[RIGHT*CNT_WIDTH +: CNT_WIDTH];
            // Results are loaded here so they are already stable while sample_valid is high in PUB.
            if (run && state == ST_CALC) begin
                count_l    <= cap_l;
                count_r    <= cap_r;
                delta_l    <= prev_valid ? cap_l - prev_l : '0;
                delta_r    <= prev_valid ? cap_r - prev_r : '0;
                prev_l     <= cap_l;
                prev_r     <= cap_r;
                prev_valid <= 1'b1;
                seq        <= seq + 8'd1;
            end
            // A clear coinciding with a publish is swallowed: irq stays set and overrun is left alone.
            if (sample_valid) begin
                irq <= 1'b1;
                if (irq && !irq_clr) overrun <= 1'b1;
            end else if (irq_clr) begin
                irq     <= 1'b0;
                overrun <= 1'b0;
                miss    <= 1'b0;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
                err     <= 1'b0;
`endif
            end
            if (expire && state != ST_WAIT) miss <= 1'b1;
`ifdef QUAD_SAMPLE_TIMEOUT_EN
            if (tmo_hit) err <= 1'b1;
            if (state == ST_ACK_L || state == ST_ACK_R) tmo <= tmo + TW'(1);
            else                                        tmo <= '0;
`endif
        end
    end

endmodule
